// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - round-robin req/ack arbiter and sequencer for one single-port synchronous RAM
module spram_arbiter #(
    parameter int data_width = 8,
    parameter int addr_width = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [addr_width-1:0] cpu_addr,
    input  logic [data_width-1:0] cpu_wdata,
    output logic [data_width-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  vid_req,
    input  logic                  vid_we,
    input  logic [addr_width-1:0] vid_addr,
    input  logic [data_width-1:0] vid_wdata,
    output logic [data_width-1:0] vid_rdata,
    output logic                  vid_ack,
    output logic [addr_width-1:0] ram_address,
    output logic [data_width-1:0] ram_data,
    output logic                  ram_wren,
    output logic                  ram_cs,
    input  logic [data_width-1:0] ram_q,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;
    logic                  grant_q;
    logic                  busy_q;
    logic                  ram_cs_q;
    logic                  ram_wren_q;
    logic [addr_width-1:0] ram_address_q;
    logic [data_width-1:0] ram_data_q;
    logic [data_width-1:0] cpu_rdata_q;
    logic [data_width-1:0] vid_rdata_q;
    logic                  cpu_ack_q;
    logic                  vid_ack_q;

    logic                  pick_vid_d;
    logic                  sel_we_d;
    logic [addr_width-1:0] sel_addr_d;
    logic [data_width-1:0] sel_wdata_d;

    // Arbitration: a lone requester wins; under contention the port that did not go last wins.
    always_comb begin
        pick_vid_d  = vid_req && (!cpu_req || !last_grant_q);
        sel_we_d    = pick_vid_d ? vid_we    : cpu_we;
        sel_addr_d  = pick_vid_d ? vid_addr  : cpu_addr;
        sel_wdata_d = pick_vid_d ? vid_wdata : cpu_wdata;
    end

    // Sequencer: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE, every output registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            busy_q        <= 1'b0;
            ram_cs_q      <= 1'b0;
            ram_wren_q    <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            cpu_rdata_q   <= '0;
            vid_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            vid_ack_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || vid_req) begin
                        grant_q       <= pick_vid_d;
                        last_grant_q  <= pick_vid_d;
                        ram_address_q <= sel_addr_d;
                        ram_data_q    <= sel_wdata_d;
                        ram_wren_q    <= sel_we_d;
                        ram_cs_q      <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The RAM has taken the access at this edge; a write must not repeat.
                    ram_wren_q <= 1'b0;
                    state_q    <= CAPTURE;
                end
                CAPTURE: begin
                    ram_cs_q <= 1'b0;
                    if (grant_q) begin
                        vid_rdata_q <= ram_q;
                        vid_ack_q   <= 1'b1;
                    end else begin
                        cpu_rdata_q <= ram_q;
                        cpu_ack_q   <= 1'b1;
                    end
                    state_q <= ACK;
                end
                ACK: begin
                    cpu_ack_q <= 1'b0;
                    vid_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign vid_rdata   = vid_rdata_q;
    assign vid_ack     = vid_ack_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign ram_cs      = ram_cs_q;
    assign busy        = busy_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - self-checking bench for spram_arbiter with RAM model and transaction-level reference
module tb_spram_arbiter;

    logic       clock;
    logic       reset_n;
    logic       cpu_req, cpu_we, vid_req, vid_we;
    logic [9:0] cpu_addr, vid_addr, ram_address;
    logic [7:0] cpu_wdata, vid_wdata, cpu_rdata, vid_rdata, ram_data;
    logic       cpu_ack, vid_ack, ram_wren, ram_cs, busy, grant;
    logic [7:0] ram_q = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit started  = 0;
    int wren_cnt = 0;
    int cpu_ack_cnt = 0;
    int vid_ack_cnt = 0;

    spram_arbiter #(.data_width(8), .addr_width(10)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_we(vid_we), .vid_addr(vid_addr), .vid_wdata(vid_wdata),
        .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_cs(ram_cs),
        .ram_q(ram_q), .busy(busy), .grant(grant)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Single-port RAM: registered read, write-through q.
    logic [7:0] ram_mem [1024];
    always @(posedge clock) begin
        if (ram_cs) begin
            if (ram_wren) begin
                ram_mem[ram_address] <= ram_data;
                ram_q                <= ram_data;
            end else begin
                ram_q <= ram_mem[ram_address];
            end
        end
    end

    // Reference: transaction view. m_cnt = cycles elapsed since the grant edge (0 = idle).
    int         m_cnt;
    logic       m_owner, m_last, m_we;
    logic [9:0] m_addr;
    logic [7:0] m_wdata, m_res;
    logic [7:0] m_rd [2];
    logic [7:0] m_mem [1024];
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_res = '0; m_rd[0] = '0; m_rd[1] = '0;
        end else if (m_cnt == 0) begin
            if (cpu_req || vid_req) begin
                m_owner = (cpu_req && vid_req) ? ~m_last : vid_req;
                m_last  = m_owner;
                m_we    = m_owner ? vid_we    : cpu_we;
                m_addr  = m_owner ? vid_addr  : cpu_addr;
                m_wdata = m_owner ? vid_wdata : cpu_wdata;
                if (m_we) m_mem[m_addr] = m_wdata;
                m_res = m_mem[m_addr];
                m_cnt = 1;
            end
        end else if (m_cnt == 3) begin
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 3) m_rd[m_owner] = m_res;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference, plus event counters.
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                check("busy",      busy,      m_cnt != 0);
                check("grant",     grant,     m_owner);
                check("ram_cs",    ram_cs,    (m_cnt == 1) || (m_cnt == 2));
                check("ram_wren",  ram_wren,  (m_cnt == 1) && m_we);
                check("cpu_ack",   cpu_ack,   (m_cnt == 3) && !m_owner);
                check("vid_ack",   vid_ack,   (m_cnt == 3) && m_owner);
                check("cpu_rdata", cpu_rdata, m_rd[0]);
                check("vid_rdata", vid_rdata, m_rd[1]);
                if (m_cnt == 1 || m_cnt == 2) begin
                    check("ram_address", ram_address, m_addr);
                    check("ram_data",    ram_data,    m_wdata);
                end
                if (ram_wren) wren_cnt++;
                if (cpu_ack) cpu_ack_cnt++;
                if (vid_ack) vid_ack_cnt++;
            end
        end
    end

    task automatic set_port(input int p, input logic r, input logic we, input logic [9:0] a, input logic [7:0] d);
        if (p == 0) begin
            cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            vid_req = r; vid_we = we; vid_addr = a; vid_wdata = d;
        end
    endtask

    task automatic wait_ack(output int port, output logic [7:0] rd, output int c);
        int n;
        port = -1; rd = '0; c = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge clock);
            if (cpu_ack) begin port = 0; rd = cpu_rdata; c = cyc; break; end
            if (vid_ack) begin port = 1; rd = vid_rdata; c = cyc; break; end
        end
        if (port < 0) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout: got no ack within 20 cycles, expected one");
        end
    endtask

    task automatic single(input int p, input logic we, input logic [9:0] a, input logic [7:0] d);
        int port, c;
        logic [7:0] rd;
        set_port(p, 1'b1, we, a, d);
        wait_ack(port, rd, c);
        check("single_port", port, p);
        if (we) check("single_wr_through", rd, d);
        @(posedge clock); #2;
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int port, c, c0, c1, c2, base;
        logic [7:0] rd;
        int exp_port [4];
        logic [7:0] exp_rd [4];
        exp_port = '{0, 1, 0, 1};
        exp_rd   = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};

        // Reset with a CPU write request already held.
        reset_n = 1'b1;
        set_port(0, 1'b1, 1'b1, 10'h001, 8'h5A);
        set_port(1, 1'b0, 1'b0, '0, '0);
        #1 reset_n = 1'b0;
        started = 1;
        repeat (2) @(negedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_cs", ram_cs, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_grant", grant, 0);
        check("rst_ack", cpu_ack, 0);
        check("rst_addr", ram_address, 0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        @(negedge clock);
        c0 = cyc;
        base = wren_cnt;
        wait_ack(port, rd, c);
        check("t1_port", port, 0);
        check("t1_grant", grant, 0);
        check("t1_latency", c - c0, 3);
        check("t1_rdata", rd, 8'h5A);
        @(posedge clock); #2;
        set_port(0, 1'b0, 1'b0, '0, '0);
        check("t1_wren_cycles", wren_cnt - base, 1);

        // CPU write then read of the same word.
        base = vid_ack_cnt;
        set_port(0, 1'b1, 1'b1, 10'h155, 8'h3C);
        wait_ack(port, rd, c);
        check("t2_wr_rdata", rd, 8'h3C);
        @(posedge clock); #2;
        set_port(0, 1'b1, 1'b0, 10'h155, 8'h00);
        wait_ack(port, rd, c);
        check("t2_rd_port", port, 0);
        check("t2_rd_rdata", rd, 8'h3C);
        @(posedge clock); #2;
        set_port(0, 1'b0, 1'b0, '0, '0);
        check("t2_no_vid_ack", vid_ack_cnt - base, 0);

        // Preload, then four transactions under continuous contention.
        single(0, 1'b1, 10'h010, 8'hA1);
        single(1, 1'b1, 10'h200, 8'hB2);
        set_port(0, 1'b1, 1'b0, 10'h010, 8'h00);
        set_port(1, 1'b1, 1'b0, 10'h200, 8'h00);
        c1 = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(port, rd, c);
            check("t3_order", port, exp_port[i]);
            check("t3_rdata", rd, exp_rd[i]);
            if (i > 0) check("t3_spacing", c - c1, 4);
            c1 = c;
        end
        @(posedge clock); #2;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Video request arriving during a CPU ISSUE cycle waits for IDLE.
        set_port(0, 1'b1, 1'b0, 10'h010, 8'h00);
        @(posedge clock); #2;
        set_port(1, 1'b1, 1'b0, 10'h200, 8'h00);
        wait_ack(port, rd, c1);
        check("t4_first", port, 0);
        check("t4_cpu_rdata", rd, 8'hA1);
        @(posedge clock); #2;
        set_port(0, 1'b0, 1'b0, '0, '0);
        wait_ack(port, rd, c2);
        check("t4_second", port, 1);
        check("t4_vid_rdata", rd, 8'hB2);
        check("t4_gap", c2 - c1, 4);
        @(posedge clock); #2;
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Asynchronous reset during CAPTURE of a CPU read.
        base = cpu_ack_cnt;
        set_port(0, 1'b1, 1'b0, 10'h010, 8'h00);
        @(posedge clock);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_cs", ram_cs, 0);
        check("t5_cpu_rdata", cpu_rdata, 0);
        check("t5_vid_rdata", vid_rdata, 0);
        check("t5_ack", cpu_ack, 0);
        set_port(0, 1'b0, 1'b0, '0, '0);
        @(posedge clock); @(posedge clock); #2;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("t5_no_ack", cpu_ack_cnt - base, 0);
        @(posedge clock); #2;
        set_port(0, 1'b1, 1'b0, 10'h010, 8'h00);
        set_port(1, 1'b1, 1'b0, 10'h200, 8'h00);
        wait_ack(port, rd, c);
        check("t5_first_after_reset", port, 0);
        check("t5_rdata", rd, 8'hA1);
        @(posedge clock); #2;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Back-to-back CPU reads at both ends of the address space.
        single(0, 1'b1, 10'h000, 8'h11);
        single(0, 1'b1, 10'h3FF, 8'hEE);
        base = cpu_ack_cnt;
        set_port(0, 1'b1, 1'b0, 10'h000, 8'h00);
        wait_ack(port, rd, c1);
        check("t6_rd0", rd, 8'h11);
        cpu_addr = 10'h3FF;
        wait_ack(port, rd, c2);
        check("t6_port", port, 0);
        check("t6_rd3ff", rd, 8'hEE);
        check("t6_gap", c2 - c1, 4);
        @(posedge clock); #2;
        set_port(0, 1'b0, 1'b0, '0, '0);
        repeat (8) @(negedge clock);
        check("t6_ack_count", cpu_ack_cnt - base, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester arbiter and sequencer for one single-port synchronous RAM (1-cycle registered read, write-through q).
- Shares the RAM between the CPU port (port 0) and the video/DMA fetch port (port 1) using req/ack handshakes and round-robin priority.
- Sits between the two bus masters and the RAM instance, and drives every RAM control input.

Parameters:
data_width, 8, RAM word width
addr_width, 10, RAM address width (2**addr_width words)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  port 0 request; held until cpu_ack
cpu_we  in  1  port 0 write enable, qualified by cpu_req
cpu_addr  in  addr_width  port 0 address
cpu_wdata  in  data_width  port 0 write data
cpu_rdata  out  data_width  port 0 read data, valid in cpu_ack cycle, held until next port 0 ack
cpu_ack  out  1  port 0 one-cycle completion strobe
vid_req, vid_we, vid_addr, vid_wdata, vid_rdata, vid_ack  same as port 0, for port 1
ram_address  out  addr_width  to RAM address
ram_data  out  data_width  to RAM data
ram_wren  out  1  to RAM write enable
ram_cs  out  1  to RAM chip select
ram_q  in  data_width  from RAM q
busy  out  1  high whenever state is not IDLE
grant  out  1  port owning the current/last transaction (0=cpu, 1=vid)

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first contention.
- Reset is asynchronous and may occur mid-transaction: the transaction is dropped with no ack, and the RAM may or may not have been written.
- All outputs are registered.
- FSM, one state per cycle: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE.
- IDLE, no req: stay in IDLE with ram_cs=0 and ram_wren=0.
- IDLE, one req: grant that port.
- IDLE, both req: grant the port != last_grant.
- On grant: latch the port's addr, we and wdata into ram_address, ram_wren and ram_data; set ram_cs=1, update grant and last_grant, and go to ISSUE.
- ISSUE: RAM samples its inputs at the end of this cycle. Next state CAPTURE; ram_wren drops to 0 entering CAPTURE, so it is high for exactly one cycle.
- CAPTURE: ram_q is valid. Copy it into the granted port's rdata register and set that port's ack for the next cycle. Deassert ram_cs. Next state ACK.
- ACK: the granted port's ack=1 for exactly one cycle. Next state IDLE.
- Requesters sample ack at the ACK-ending edge and must drop req or present a new request at that edge.
- Latency: grant edge to ack cycle = 3 cycles. Throughput: 1 access per 4 cycles, alternating under continuous contention.
- Writes: ack returns the written data in rdata (RAM write-through).
- The non-granted port's rdata and ack are unaffected; ack never asserts for both ports in the same cycle.
- Requester inputs are ignored outside IDLE.
- A req dropped before its grant is never serviced.
- ram_address and ram_data are held stable from the grant edge through CAPTURE.
- busy=1 in ISSUE, CAPTURE and ACK.
- No address-range checking: addresses wrap naturally at 2**addr_width.

Test Plan:
- Reset with cpu_req=1 held -> all outputs 0 while reset_n=0. After release, grant=0, ram_wren pulses 1 cycle, cpu_ack 3 cycles after the grant edge.
- CPU write 0x3C to 0x155, then CPU read 0x155 -> write ack with cpu_rdata=0x3C; read ack with cpu_rdata=0x3C; vid_ack stays 0 throughout.
- cpu_req and vid_req both held high for 4 transactions (cpu addr 0x010, vid addr 0x200, preloaded 0xA1/0xB2) -> grant order 0,1,0,1; acks alternate; cpu_rdata=0xA1, vid_rdata=0xB2; 4 cycles between acks.
- vid_req asserted during a CPU transaction's ISSUE cycle -> video is not granted until IDLE, then granted immediately; vid_ack 4 cycles after cpu_ack.
- reset_n pulsed low during CAPTURE of a CPU read -> no cpu_ack; outputs 0 immediately (asynchronously); port 0 is granted first on the next contention.
- Back-to-back CPU reads of 0x000 and 0x3FF, new request presented in the ack cycle -> second grant on the edge after ACK, rdata values correct, no duplicate ack.
